spi_word_sequencer: RTL and testbench
=====================================

Name: spi_word_sequencer

Overview:
Parametrised serial word writer for AD9833-class DDS/DAC parts with a 3-wire FSYNC/SCLK/SDATA interface.
- Shifts a programmable count of words (control, freq LSB/MSB, phase, ...) from a parallel bundle, MSB first, in one triggered sequence.
- Drives FSYNC low per word and raises it between words.
- Sits between the config/register logic and the device pins; handshake is start/busy/done.

Parameters:
WORD_W, 16, bits per serial word (>=2)
NUM_WORDS, 4, maximum words per sequence (>=1)
CLKS_PER_BIT, 10, clk cycles per SCLK period; even, >=2
LEAD_CLKS, 10, cycles FSYNC is low before the first bit of each word (>=1)
GAP_CLKS, 4, cycles FSYNC is held high after each word (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  request; sampled only in IDLE
words_in  in  NUM_WORDS*WORD_W  word i at [i*WORD_W +: WORD_W]; word 0 sent first
word_count  in  $clog2(NUM_WORDS+1)  number of words to send
busy  out  1  high from the cycle after start is accepted until the sequence ends
done  out  1  one-cycle completion pulse
fsync  out  1  frame sync, active low
sclk  out  1  serial clock, idles high
sdata  out  1  serial data

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state IDLE; fsync=1, sclk=1, sdata=0, busy=0, done=0
  - all counters cleared; any sequence in flight is dropped with no done pulse
- Every output is a register; there is no combinational path from inputs to outputs.
- States: IDLE, LEAD, SHIFT, GAP, FIN.
- IDLE:
  - start=1 latches words_in and word_count (clamped to NUM_WORDS); input changes after this have no effect.
  - Latched count 0 -> FIN with no FSYNC activity.
  - Otherwise -> LEAD. busy=1 and fsync=0 take effect on the next cycle.
- LEAD:
  - fsync=0, sclk=1 for LEAD_CLKS cycles, then -> SHIFT with bit index WORD_W-1.
- SHIFT, per bit (CLKS_PER_BIT cycles):
  - cycle 0: sdata <= current bit, sclk=1.
  - cycle CLKS_PER_BIT/2: sclk <= 0; the falling edge is the device sample point.
  - last cycle: sclk <= 1 and the bit index decrements.
  - After bit 0 completes -> GAP; sclk=1 and sdata holds bit 0.
- GAP:
  - fsync=1 for GAP_CLKS cycles.
  - If more words remain, the word index increments -> LEAD; otherwise -> FIN.
- FIN:
  - single cycle: done=1, busy=0, sdata=0 -> IDLE.
- Timing:
  - Per-word length is LEAD_CLKS + WORD_W*CLKS_PER_BIT + GAP_CLKS cycles. With defaults this is 174.
  - With start accepted at edge 0, done is high during cycle 1 + N*174.
  - A new start is accepted on the cycle after done, giving back-to-back sequences.
- start while busy is ignored and not queued.
- Bit counter is $clog2(WORD_W) wide; word counter is $clog2(NUM_WORDS+1) wide; clock counter is $clog2(max(LEAD_CLKS, CLKS_PER_BIT, GAP_CLKS)+1) wide. No wrap occurs within legal parameters.

Optional Feature:
SPI_WORD_SEQ_ABORT_EN:
- Defined: adds input abort (1 bit).
  - abort=1 while busy: next cycle fsync=1, sclk=1, sdata=0, busy=0, done=0, state IDLE. The partial word is discarded.
  - abort and start in the same IDLE cycle: start is ignored.
  - abort in IDLE has no effect.
- Undefined: no abort port; a sequence always runs to FIN.

Test Plan:
- Reset: hold rst_n=0 mid-SHIFT for 2 cycles -> fsync=1, sclk=1, sdata=0, busy=0, no done pulse; the next start runs a full sequence.
- Single word: defaults, word_count=1, word0=16'h2100, start at edge 0 -> 16 falling sclk edges sampling 0010_0001_0000_0000 MSB first; fsync low for 170 cycles; done in cycle 175.
- Three words: 16'h2100, 16'h50C7, 16'h4000 -> three fsync-low frames separated by 4 high cycles; the decoded words match; done in cycle 523.
- Zero/clamp: word_count=0 -> done in cycle 2, fsync never low. word_count=7 with NUM_WORDS=4 -> exactly 4 frames.
- Busy protection and back-to-back: pulse start mid-sequence -> ignored, frame count unchanged. Assert start the cycle after done -> second sequence begins, busy high again next cycle.
- Abort (SPI_WORD_SEQ_ABORT_EN): abort at bit 7 of word 1 -> fsync=1, busy=0 next cycle, no done; a following start sends word 0 correctly.

Source files
------------

// File: rtl/spi_word_sequencer.sv
// Purpose : serial word writer for AD9833-class parts (FSYNC/SCLK/SDATA), MSB first.
// Latency : start accepted at edge 0 -> done high for one cycle, 1 + N*(LEAD+WORD_W*CLKS_PER_BIT+GAP) cycles later (count 0: cycle 2).
// Backpr. : none; start is sampled only in IDLE, and a start while busy is dropped, not queued.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   start             sequence request (IDLE only)
//   words_in          word i at [i*WORD_W +: WORD_W], word 0 sent first
//   word_count        words to send, clamped to NUM_WORDS
//   busy, done        status: busy during the sequence, done one-cycle pulse at the end
//   fsync, sclk, sdata device pins (fsync active low, sclk idles high)
//   abort             only with SPI_WORD_SEQ_ABORT_EN defined: drop the sequence in flight
//
// Optional feature macro: SPI_WORD_SEQ_ABORT_EN (adds the abort input).
module spi_word_sequencer #(
    parameter int WORD_W       = 16,
    parameter int NUM_WORDS    = 4,
    parameter int CLKS_PER_BIT = 10,
    parameter int LEAD_CLKS    = 10,
    parameter int GAP_CLKS     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [NUM_WORDS*WORD_W-1:0]      words_in,
    input  logic [$clog2(NUM_WORDS+1)-1:0]   word_count,
`ifdef SPI_WORD_SEQ_ABORT_EN
    input  logic                             abort,
`endif
    output logic                             busy,
    output logic                             done,
    output logic                             fsync,
    output logic                             sclk,
    output logic                             sdata
);

    localparam int WCW    = $clog2(NUM_WORDS + 1);
    localparam int BW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int MAXC_A = (LEAD_CLKS > CLKS_PER_BIT) ? LEAD_CLKS : CLKS_PER_BIT;
    localparam int MAXC   = (MAXC_A > GAP_CLKS) ? MAXC_A : GAP_CLKS;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0]  LEAD_LAST = CW'(LEAD_CLKS - 1);
    localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP_CLKS - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    // sclk is registered, so the fall is scheduled one cycle early to be
    // visible exactly at the half-period cycle.
    localparam logic [CW-1:0]  FALL_AT   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]  BIT_TOP   = BW'(WORD_W - 1);
    localparam logic [WCW-1:0] NW_MAX    = WCW'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_GAP,
        S_FIN
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]                 bit_idx_q, bit_idx_d;
    logic [WCW-1:0]                word_idx_q, word_idx_d;
    logic [WCW-1:0]                count_q, count_d;
    logic [NUM_WORDS*WORD_W-1:0]   words_q, words_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          fsync_q, fsync_d;
    logic                          sclk_q, sclk_d;
    logic                          sdata_q, sdata_d;

    logic                          abort_req;
    logic [WORD_W-1:0]             cur_word;
    logic [BW-1:0]                 bit_idx_dec;
    logic [WCW-1:0]                count_clamped;

`ifdef SPI_WORD_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign busy  = busy_q;
    assign done  = done_q;
    assign fsync = fsync_q;
    assign sclk  = sclk_q;
    assign sdata = sdata_q;

    assign bit_idx_dec   = bit_idx_q - BW'(1);
    assign count_clamped = (word_count > NW_MAX) ? NW_MAX : word_count;

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (word_idx_q == WCW'(i)) begin
                cur_word = words_q[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        words_d    = words_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fsync_d    = fsync_q;
        sclk_d     = sclk_q;
        sdata_d    = sdata_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort_req) begin
                    words_d    = words_in;
                    count_d    = count_clamped;
                    word_idx_d = '0;
                    busy_d     = 1'b1;
                    clk_cnt_d  = '0;
                    if (count_clamped == '0) begin
                        // Empty request: pass through a one-cycle GAP (fsync
                        // stays high) so it ends through the normal FIN path.
                        state_d   = S_GAP;
                        clk_cnt_d = GAP_LAST;
                    end else begin
                        state_d = S_LEAD;
                        fsync_d = 1'b0;
                    end
                end
            end

            S_LEAD: begin
                if (clk_cnt_q == LEAD_LAST) begin
                    state_d   = S_SHIFT;
                    clk_cnt_d = '0;
                    bit_idx_d = BIT_TOP;
                    // First bit is on the pin from cycle 0 of its period.
                    sdata_d   = cur_word[BIT_TOP];
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            S_SHIFT: begin
                if (clk_cnt_q == FALL_AT) begin
                    sclk_d = 1'b0;
                end
                if (clk_cnt_q == BIT_LAST) begin
                    sclk_d    = 1'b1;
                    clk_cnt_d = '0;
                    if (bit_idx_q == '0) begin
                        state_d = S_GAP;
                        fsync_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_dec;
                        sdata_d   = cur_word[bit_idx_dec];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            S_GAP: begin
                if (clk_cnt_q == GAP_LAST) begin
                    clk_cnt_d = '0;
                    if ((word_idx_q + WCW'(1)) < count_q) begin
                        word_idx_d = word_idx_q + WCW'(1);
                        state_d    = S_LEAD;
                        fsync_d    = 1'b0;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        sdata_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything while a sequence is in flight; busy_q is
        // low in IDLE and FIN, so an abort there does nothing.
        if (abort_req && busy_q) begin
            state_d    = S_IDLE;
            clk_cnt_d  = '0;
            bit_idx_d  = '0;
            word_idx_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            fsync_d    = 1'b1;
            sclk_d     = 1'b1;
            sdata_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            words_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fsync_q    <= 1'b1;
            sclk_q     <= 1'b1;
            sdata_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            words_q    <= words_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fsync_q    <= fsync_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
        end
    end

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Purpose : directed self-checking bench for spi_word_sequencer (default parameters).
// Latency : cycle c is the period after clock edge c-1; the accepting edge is edge 0.
// Backpr. : n/a (bench); outputs are sampled on the falling clock edge.
module tb_spi_word_sequencer;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] words_in;
    logic [2:0]  word_count;
`ifdef SPI_WORD_SEQ_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic        done;
    logic        fsync;
    logic        sclk;
    logic        sdata;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations collected by observe()
    logic [15:0] dec [8];
    int          nbits [8];
    int          done_cyc;
    int          frames;
    int          low_cyc;
    int          gap_bad;
    logic        busy_c1;

    always #5 clk = ~clk;

    spi_word_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .words_in   (words_in),
        .word_count (word_count),
`ifdef SPI_WORD_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .fsync      (fsync),
        .sclk       (sclk),
        .sdata      (sdata)
    );

    // Caller raises start at a negedge; this waits for the accepting edge,
    // drops start, then decodes the pins until done or the cycle budget ends.
    task automatic observe(input int max_cyc, input int poke_cyc, input bit scramble);
        logic        pf, ps;
        logic [15:0] sh;
        int          hi_run, nb;
        done_cyc = 0; frames = 0; low_cyc = 0; gap_bad = 0; busy_c1 = 1'b0;
        for (int i = 0; i < 8; i++) begin dec[i] = 16'h0; nbits[i] = 0; end
        pf = 1'b1; ps = 1'b1; sh = 16'h0; nb = 0; hi_run = 0;
        @(posedge clk);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin start = 1'b0; busy_c1 = busy; end
            if (scramble && cyc == 2) begin words_in = 64'hDEAD_BEEF_0BAD_F00D; word_count = 3'd4; end
            if (poke_cyc != 0 && cyc == poke_cyc) start = 1'b1;
            if (poke_cyc != 0 && cyc == poke_cyc + 1) start = 1'b0;
            if (!fsync) low_cyc++;
            if (pf && !fsync) begin
                frames++;
                if (frames > 1 && hi_run != GAP) gap_bad++;
                sh = 16'h0; nb = 0;
            end
            if (!pf && fsync && frames >= 1 && frames <= 8) begin
                dec[frames-1]   = sh;
                nbits[frames-1] = nb;
            end
            if (ps && !sclk && !fsync) begin sh = {sh[14:0], sdata}; nb++; end
            hi_run = fsync ? hi_run + 1 : 0;
            pf = fsync; ps = sclk;
            if (done) begin done_cyc = cyc; break; end
        end
    endtask

    task automatic test_reset();
        int seen_done, lows;
        @(negedge clk);
        tests_run++; if (fsync !== 1'b1) begin tests_failed++; $display("FAIL rst_fsync got=%b exp=1", fsync); end
        tests_run++; if (sclk  !== 1'b1) begin tests_failed++; $display("FAIL rst_sclk got=%b exp=1", sclk); end
        tests_run++; if (sdata !== 1'b0) begin tests_failed++; $display("FAIL rst_sdata got=%b exp=0", sdata); end
        tests_run++; if (busy  !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tests_run++; if (done  !== 1'b0) begin tests_failed++; $display("FAIL rst_done got=%b exp=0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        words_in = {48'h0, 16'hFFFF}; word_count = 3'd1; start = 1'b1;
        @(posedge clk);
        repeat (50) begin @(negedge clk); start = 1'b0; end
        // cycle 50 sits inside the SHIFT phase of word 0
        tests_run++; if (fsync !== 1'b0) begin tests_failed++; $display("FAIL midshift_fsync got=%b exp=0", fsync); end
        rst_n = 1'b0;
        seen_done = 0;
        repeat (2) begin @(posedge clk); @(negedge clk); if (done) seen_done++; end
        tests_run++; if (fsync !== 1'b1) begin tests_failed++; $display("FAIL rst2_fsync got=%b exp=1", fsync); end
        tests_run++; if (sclk  !== 1'b1) begin tests_failed++; $display("FAIL rst2_sclk got=%b exp=1", sclk); end
        tests_run++; if (sdata !== 1'b0) begin tests_failed++; $display("FAIL rst2_sdata got=%b exp=0", sdata); end
        tests_run++; if (busy  !== 1'b0) begin tests_failed++; $display("FAIL rst2_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        lows = 0;
        repeat (200) begin @(negedge clk); if (done) seen_done++; if (!fsync) lows++; end
        tests_run++; if (seen_done !== 0) begin tests_failed++; $display("FAIL rst_no_done got=%0d exp=0", seen_done); end
        tests_run++; if (lows !== 0) begin tests_failed++; $display("FAIL rst_no_frame got=%0d exp=0", lows); end
    endtask

    task automatic test_single();
        @(negedge clk);
        words_in = {48'h0, 16'h2100}; word_count = 3'd1; start = 1'b1;
        observe(400, 0, 1'b0);
        tests_run++; if (busy_c1 !== 1'b1) begin tests_failed++; $display("FAIL single_busy_c1 got=%b exp=1", busy_c1); end
        tests_run++; if (done_cyc !== 175) begin tests_failed++; $display("FAIL single_done_cyc got=%0d exp=175", done_cyc); end
        tests_run++; if (frames !== 1) begin tests_failed++; $display("FAIL single_frames got=%0d exp=1", frames); end
        tests_run++; if (low_cyc !== 170) begin tests_failed++; $display("FAIL single_fsync_low got=%0d exp=170", low_cyc); end
        tests_run++; if (nbits[0] !== 16) begin tests_failed++; $display("FAIL single_nbits got=%0d exp=16", nbits[0]); end
        tests_run++; if (dec[0] !== 16'h2100) begin tests_failed++; $display("FAIL single_word got=%h exp=2100", dec[0]); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_fin_busy got=%b exp=0", busy); end
        tests_run++; if (sdata !== 1'b0) begin tests_failed++; $display("FAIL single_fin_sdata got=%b exp=0", sdata); end
    endtask

    task automatic test_three();
        @(negedge clk);
        words_in = {16'h0, 16'h4000, 16'h50C7, 16'h2100}; word_count = 3'd3; start = 1'b1;
        observe(1000, 0, 1'b1);   // inputs are scrambled after acceptance
        tests_run++; if (done_cyc !== 523) begin tests_failed++; $display("FAIL three_done_cyc got=%0d exp=523", done_cyc); end
        tests_run++; if (frames !== 3) begin tests_failed++; $display("FAIL three_frames got=%0d exp=3", frames); end
        tests_run++; if (low_cyc !== 510) begin tests_failed++; $display("FAIL three_fsync_low got=%0d exp=510", low_cyc); end
        tests_run++; if (gap_bad !== 0) begin tests_failed++; $display("FAIL three_gap_len got=%0d bad gaps exp=0", gap_bad); end
        tests_run++; if (dec[0] !== 16'h2100) begin tests_failed++; $display("FAIL three_word0 got=%h exp=2100", dec[0]); end
        tests_run++; if (dec[1] !== 16'h50C7) begin tests_failed++; $display("FAIL three_word1 got=%h exp=50c7", dec[1]); end
        tests_run++; if (dec[2] !== 16'h4000) begin tests_failed++; $display("FAIL three_word2 got=%h exp=4000", dec[2]); end
    endtask

    task automatic test_zero_clamp();
        @(negedge clk);
        words_in = {48'h0, 16'hFFFF}; word_count = 3'd0; start = 1'b1;
        observe(20, 0, 1'b0);
        tests_run++; if (busy_c1 !== 1'b1) begin tests_failed++; $display("FAIL zero_busy_c1 got=%b exp=1", busy_c1); end
        tests_run++; if (done_cyc !== 2) begin tests_failed++; $display("FAIL zero_done_cyc got=%0d exp=2", done_cyc); end
        tests_run++; if (low_cyc !== 0) begin tests_failed++; $display("FAIL zero_fsync_low got=%0d exp=0", low_cyc); end
        @(negedge clk);
        words_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111}; word_count = 3'd7; start = 1'b1;
        observe(2000, 0, 1'b0);
        tests_run++; if (frames !== 4) begin tests_failed++; $display("FAIL clamp_frames got=%0d exp=4", frames); end
        tests_run++; if (done_cyc !== 697) begin tests_failed++; $display("FAIL clamp_done_cyc got=%0d exp=697", done_cyc); end
        tests_run++; if (dec[0] !== 16'h1111) begin tests_failed++; $display("FAIL clamp_word0 got=%h exp=1111", dec[0]); end
        tests_run++; if (dec[3] !== 16'h4444) begin tests_failed++; $display("FAIL clamp_word3 got=%h exp=4444", dec[3]); end
    endtask

    task automatic test_busy_ignore();
        int lows;
        @(negedge clk);
        words_in = {32'h0, 16'hBEEF, 16'hCAFE}; word_count = 3'd2; start = 1'b1;
        observe(1000, 100, 1'b0);
        tests_run++; if (frames !== 2) begin tests_failed++; $display("FAIL busy_frames got=%0d exp=2", frames); end
        tests_run++; if (done_cyc !== 349) begin tests_failed++; $display("FAIL busy_done_cyc got=%0d exp=349", done_cyc); end
        tests_run++; if (dec[1] !== 16'hBEEF) begin tests_failed++; $display("FAIL busy_word1 got=%h exp=beef", dec[1]); end
        lows = 0;
        repeat (400) begin @(negedge clk); if (!fsync || busy) lows++; end
        tests_run++; if (lows !== 0) begin tests_failed++; $display("FAIL busy_not_queued got=%0d active cycles exp=0", lows); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        words_in = {48'h0, 16'hA5A5}; word_count = 3'd1; start = 1'b1;
        observe(400, 0, 1'b0);
        tests_run++; if (done_cyc !== 175) begin tests_failed++; $display("FAIL b2b_first_done got=%0d exp=175", done_cyc); end
        tests_run++; if (dec[0] !== 16'hA5A5) begin tests_failed++; $display("FAIL b2b_first_word got=%h exp=a5a5", dec[0]); end
        @(negedge clk);   // cycle after done: sequencer is idle
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        words_in = {48'h0, 16'h1234}; start = 1'b1;
        observe(400, 0, 1'b0);
        tests_run++; if (busy_c1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy_again got=%b exp=1", busy_c1); end
        tests_run++; if (done_cyc !== 175) begin tests_failed++; $display("FAIL b2b_second_done got=%0d exp=175", done_cyc); end
        tests_run++; if (dec[0] !== 16'h1234) begin tests_failed++; $display("FAIL b2b_second_word got=%h exp=1234", dec[0]); end
    endtask

`ifdef SPI_WORD_SEQ_ABORT_EN
    task automatic test_abort();
        int dones, lows;
        @(negedge clk);
        words_in = {32'h0, 16'h50C7, 16'h2100}; word_count = 3'd2; start = 1'b1;
        @(posedge clk);
        // word 1 shift starts at cycle 185; bit 7 occupies cycles 265..274
        for (int cyc = 1; cyc <= 268; cyc++) begin @(negedge clk); start = 1'b0; end
        tests_run++; if (fsync !== 1'b0) begin tests_failed++; $display("FAIL abort_pre_frame got=%b exp=0", fsync); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++; if (fsync !== 1'b1) begin tests_failed++; $display("FAIL abort_fsync got=%b exp=1", fsync); end
        tests_run++; if (sclk  !== 1'b1) begin tests_failed++; $display("FAIL abort_sclk got=%b exp=1", sclk); end
        tests_run++; if (sdata !== 1'b0) begin tests_failed++; $display("FAIL abort_sdata got=%b exp=0", sdata); end
        tests_run++; if (busy  !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tests_run++; if (done  !== 1'b0) begin tests_failed++; $display("FAIL abort_done got=%b exp=0", done); end
        dones = 0; lows = 0;
        repeat (400) begin @(negedge clk); if (done) dones++; if (!fsync) lows++; end
        tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        tests_run++; if (lows !== 0) begin tests_failed++; $display("FAIL abort_no_frame got=%0d exp=0", lows); end
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_start_same got=%b exp=0", busy); end
        word_count = 3'd1; start = 1'b1;
        observe(400, 0, 1'b0);
        tests_run++; if (done_cyc !== 175) begin tests_failed++; $display("FAIL abort_after_done got=%0d exp=175", done_cyc); end
        tests_run++; if (dec[0] !== 16'h2100) begin tests_failed++; $display("FAIL abort_after_word got=%h exp=2100", dec[0]); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; words_in = 64'h0; word_count = 3'd0;
`ifdef SPI_WORD_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_three();
        test_zero_clamp();
        test_busy_ignore();
        test_back_to_back();
`ifdef SPI_WORD_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
